// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Counter width that stays legal for a terminal count of 1.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: reports calls above, below and at a given floor.
module elevator_req_scan #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] eff,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  above,
  output logic                  below,
  output logic                  here
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    // Empty ranges (top floor / bottom floor) fall out naturally as 0.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor)) above = above | eff[i];
      if (i < int'(floor)) below = below | eff[i];
    end
    here = eff[floor];
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor elevator car controller with SCAN scheduling: latches calls, moves one
// floor per TRAVEL_CYCLES, holds the door for DOOR_CYCLES, keeps direction while calls lie ahead.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    car_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TCNT_W = cnt_width(TRAVEL_CYCLES);
  localparam int DCNT_W = cnt_width(DOOR_CYCLES);
  localparam logic [TCNT_W-1:0] TRAVEL_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DOOR_LAST   = DCNT_W'(DOOR_CYCLES - 1);

  state_t              state, state_next;
  logic [FLOOR_W-1:0]  floor_next, step_floor;
  logic                dir_next;
  logic [TCNT_W-1:0]   travel_cnt, travel_cnt_next;
  logic [DCNT_W-1:0]   door_cnt, door_cnt_next;
  logic                arrive_next;
  logic [NUM_FLOORS-1:0] pending_next, served, eff;

  logic above, below, here;
  logic above_step, below_step, here_step;
  logic ahead_step, behind_step;

  // Calls are visible to the scheduler in the same cycle they are raised.
  assign eff        = pending | call_req;
  assign step_floor = dir_up ? car_floor + FLOOR_W'(1) : car_floor - FLOOR_W'(1);

  elevator_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan_cur (
    .eff   (eff),
    .floor (car_floor),
    .above (above),
    .below (below),
    .here  (here)
  );

  // Second scan looks at the floor the car is about to reach, so the
  // arrival decision is made on the same edge as the floor update.
  elevator_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan_step (
    .eff   (eff),
    .floor (step_floor),
    .above (above_step),
    .below (below_step),
    .here  (here_step)
  );

  assign ahead_step  = dir_up ? above_step : below_step;
  assign behind_step = dir_up ? below_step : above_step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      car_floor  <= '0;
      dir_up     <= DIR_UP;
      pending    <= '0;
      travel_cnt <= '0;
      door_cnt   <= '0;
      arrive     <= 1'b0;
    end else begin
      state      <= state_next;
      car_floor  <= floor_next;
      dir_up     <= dir_next;
      pending    <= pending_next;
      travel_cnt <= travel_cnt_next;
      door_cnt   <= door_cnt_next;
      arrive     <= arrive_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    floor_next      = car_floor;
    dir_next        = dir_up;
    travel_cnt_next = travel_cnt;
    door_cnt_next   = door_cnt;
    arrive_next     = 1'b0;
    served          = '0;

    unique case (state)
      IDLE: begin
        if (here) begin
          state_next         = DOOR;
          door_cnt_next      = '0;
          served[car_floor]  = 1'b1;
        end else if (above && (dir_up || !below)) begin
          state_next      = MOVING;
          dir_next        = DIR_UP;
          travel_cnt_next = '0;
        end else if (below) begin
          state_next      = MOVING;
          dir_next        = DIR_DOWN;
          travel_cnt_next = '0;
        end
      end

      MOVING: begin
        if (travel_cnt == TRAVEL_LAST) begin
          floor_next      = step_floor;
          arrive_next     = 1'b1;
          travel_cnt_next = '0;
          if (here_step) begin
            state_next         = DOOR;
            door_cnt_next      = '0;
            served[step_floor] = 1'b1;
          end else if (ahead_step) begin
            state_next = MOVING;
          end else if (behind_step) begin
            dir_next   = ~dir_up;
          end else begin
            state_next = IDLE;
          end
        end else begin
          travel_cnt_next = travel_cnt + TCNT_W'(1);
        end
      end

      DOOR: begin
        served[car_floor] = 1'b1;
        // A fresh call at this floor is absorbed and keeps the door open.
        if (here) begin
          door_cnt_next = '0;
        end else if (door_cnt == DOOR_LAST) begin
          state_next    = IDLE;
          door_cnt_next = '0;
        end else begin
          door_cnt_next = door_cnt + DCNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    pending_next = (pending | call_req) & ~served;
  end

  always_comb begin
    moving    = (state == MOVING);
    door_open = (state == DOOR);
  end

endmodule
